id_ex_pipe: RTL and testbench

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/id_ex_pipe.sv | 71 +++++++
 tb/tb_id_ex_pipe.sv | 111 +++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with one skid slot and registered outputs.
// Define ID_EX_HAZARD_EN to enable the load-use hazard stall.
module id_ex_pipe #(
  parameter int PC_WIDTH      = 12,
  parameter int DATA_WIDTH    = 16,
  parameter int REGADDR_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     id_valid,
  output logic                     id_ready,
  input  logic [6:0]               id_ctrl,
  input  logic [PC_WIDTH-1:0]      id_pc,
  input  logic [DATA_WIDTH-1:0]    id_read_data1,
  input  logic [DATA_WIDTH-1:0]    id_read_data2,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [REGADDR_WIDTH-1:0] id_rs,
  input  logic [REGADDR_WIDTH-1:0] id_rt,
  input  logic [REGADDR_WIDTH-1:0] id_rd,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [6:0]               ex_ctrl,
  output logic [PC_WIDTH-1:0]      ex_pc,
  output logic [DATA_WIDTH-1:0]    ex_read_data1,
  output logic [DATA_WIDTH-1:0]    ex_read_data2,
  output logic [DATA_WIDTH-1:0]    ex_imm,
  output logic [REGADDR_WIDTH-1:0] ex_rs,
  output logic [REGADDR_WIDTH-1:0] ex_rt,
  output logic [REGADDR_WIDTH-1:0] ex_rd,
  output logic                     hazard_stall
);
  localparam int EW = 7 + PC_WIDTH + 3 * DATA_WIDTH + 3 * REGADDR_WIDTH;
  logic [EW-1:0] r_out, r_skid;
  logic          r_out_valid, r_skid_valid;
  logic [EW-1:0] w_in;
  logic          w_hz, w_up;
  assign w_in = {id_ctrl, id_pc, id_read_data1, id_read_data2, id_imm, id_rs, id_rt, id_rd};
  assign {ex_ctrl, ex_pc, ex_read_data1, ex_read_data2, ex_imm, ex_rs, ex_rt, ex_rd} = r_out;
  assign ex_valid = r_out_valid;
`ifdef ID_EX_HAZARD_EN
  assign w_hz = id_valid && r_out_valid && ex_ctrl[5] && ex_rd != '0 && (id_rs == ex_rd || id_rt == ex_rd);
`else
  assign w_hz = 1'b0;
`endif
  assign hazard_stall = w_hz;
  assign id_ready = !r_skid_valid && !w_hz;
  assign w_up = id_valid && id_ready;
  // ctrl field is cleared whenever OUT goes empty so bubbles carry no control
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid      <= 1'b0;
      r_skid_valid     <= 1'b0;
      r_out[EW-1 -: 7] <= '0;
    end else if (!r_out_valid || ex_ready) begin
      r_out_valid  <= r_skid_valid || w_up;
      r_skid_valid <= 1'b0;
      if (r_skid_valid) r_out <= r_skid;
      else if (w_up) r_out <= w_in;
      else r_out[EW-1 -: 7] <= '0;
    end else if (w_up) begin
      r_skid       <= w_in;
      r_skid_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed plus random checks of id_ex_pipe against a queue model.
module tb_id_ex_pipe;
  typedef struct packed {
    logic [6:0]  ctrl;
    logic [11:0] pc;
    logic [15:0] d1, d2, imm;
    logic [2:0]  rs, rt, rd;
  } ent_t;
  logic clk = 0, reset, flush, id_valid, id_ready, ex_valid, ex_ready, hazard_stall;
  logic [6:0] id_ctrl, ex_ctrl;
  logic [11:0] id_pc, ex_pc;
  logic [15:0] id_read_data1, id_read_data2, id_imm, ex_read_data1, ex_read_data2, ex_imm;
  logic [2:0] id_rs, id_rt, id_rd, ex_rs, ex_rt, ex_rd;
  ent_t q[$];
  ent_t m_last;
  int pass_n = 0, tot_n = 0;
  always #5 clk = ~clk;
  id_ex_pipe dut (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_ctrl(id_ctrl), .id_pc(id_pc), .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
    .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .hazard_stall(hazard_stall)
  );
  task automatic chk(input string tag, input logic [75:0] got, input logic [75:0] exp);
    tot_n++;
    assert (got === exp) pass_n++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  function automatic ent_t mk(input logic [11:0] pc, input logic [6:0] ctrl,
                              input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
    ent_t e;
    e.ctrl = ctrl; e.pc = pc; e.rs = rs; e.rt = rt; e.rd = rd;
    e.d1 = 16'($urandom); e.d2 = 16'($urandom); e.imm = 16'($urandom);
    return e;
  endfunction
  // One clock: drive inputs, compare against the model, then advance the model at the edge.
  task automatic cyc(input bit rst, input bit fl, input bit iv, input bit er, input ent_t e, input string tag);
    ent_t exp;
    bit hz, rdy;
    reset = rst; flush = fl; id_valid = iv; ex_ready = er;
    {id_ctrl, id_pc, id_read_data1, id_read_data2, id_imm, id_rs, id_rt, id_rd} = e;
    #1;
    hz = 0;
`ifdef ID_EX_HAZARD_EN
    hz = iv && q.size() > 0 && q[0].ctrl[5] && q[0].rd != 0 && (e.rs == q[0].rd || e.rt == q[0].rd);
`endif
    rdy = q.size() < 2 && !hz;
    exp = m_last;
    exp.ctrl = 7'b0;
    if (q.size() > 0) exp = q[0];
    chk({tag, ":entry"}, {ex_ctrl, ex_pc, ex_read_data1, ex_read_data2, ex_imm, ex_rs, ex_rt, ex_rd}, exp);
    chk({tag, ":ex_valid"}, 76'(ex_valid), 76'(q.size() > 0));
    chk({tag, ":id_ready"}, 76'(id_ready), 76'(rdy));
    chk({tag, ":hazard"}, 76'(hazard_stall), 76'(hz));
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_last = '0;
    end else if (fl) q.delete();
    else begin
      if (q.size() > 0 && er) void'(q.pop_front());
      if (iv && rdy) q.push_back(e);
    end
    if (q.size() > 0) m_last = q[0];
    @(negedge clk);
  endtask
  initial begin
    ent_t z, e;
    z = '0;
    reset = 1; flush = 0; id_valid = 0; ex_ready = 0;
    {id_ctrl, id_pc, id_read_data1, id_read_data2, id_imm, id_rs, id_rt, id_rd} = z;
    @(posedge clk);
    @(negedge clk);
    m_last = '0;
    cyc(1, 0, 0, 0, z, "reset");
    cyc(0, 0, 0, 1, z, "post_reset");
    e = '{ctrl: 7'b1001011, pc: 12'hABC, d1: 16'hAAAA, d2: 16'hBBBB, imm: 16'h1234, rs: 3'd1, rt: 3'd2, rd: 3'd3};
    cyc(0, 0, 1, 1, e, "single_in");
    cyc(0, 0, 0, 1, z, "single_out");
    for (int i = 1; i <= 8; i++) cyc(0, 0, 1, 1, mk(12'(i), 7'b1000001, 3'd1, 3'd2, 3'd4), "stream");
    cyc(0, 0, 0, 1, z, "stream_tail");
    cyc(0, 0, 1, 0, mk(12'h010, 7'b1000010, 3'd1, 3'd2, 3'd4), "bp_10");
    cyc(0, 0, 1, 0, mk(12'h011, 7'b1000010, 3'd1, 3'd2, 3'd4), "bp_11");
    e = mk(12'h012, 7'b1000010, 3'd1, 3'd2, 3'd4);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, e, "bp_full");
    cyc(0, 0, 1, 1, e, "bp_drain");
    cyc(0, 0, 1, 1, e, "bp_accept12");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, z, "bp_tail");
    cyc(0, 0, 1, 0, mk(12'h018, 7'b1111111, 3'd1, 3'd2, 3'd4), "fl_a");
    cyc(0, 0, 1, 0, mk(12'h019, 7'b1111111, 3'd1, 3'd2, 3'd4), "fl_b");
    cyc(0, 1, 1, 0, mk(12'h01A, 7'b1111111, 3'd1, 3'd2, 3'd4), "flush");
    cyc(0, 0, 1, 1, mk(12'h020, 7'b1000001, 3'd1, 3'd2, 3'd4), "post_flush");
    cyc(0, 0, 0, 1, z, "post_flush_out");
    cyc(0, 0, 1, 0, mk(12'h030, 7'b1100000, 3'd1, 3'd2, 3'd3), "hz_load");
    cyc(0, 0, 1, 0, mk(12'h031, 7'b1000000, 3'd3, 3'd5, 3'd6), "hz_rs");
    cyc(0, 0, 1, 0, mk(12'h032, 7'b1000000, 3'd5, 3'd3, 3'd6), "hz_rt");
    cyc(0, 1, 0, 0, z, "hz_flush");
    cyc(0, 0, 1, 0, mk(12'h033, 7'b1100000, 3'd1, 3'd2, 3'd0), "hz_load_r0");
    cyc(0, 0, 1, 0, mk(12'h034, 7'b1000000, 3'd0, 3'd0, 3'd6), "hz_r0");
    cyc(0, 0, 1, 0, mk(12'h035, 7'b1000000, 3'd0, 3'd0, 3'd6), "rst_full");
    cyc(1, 0, 1, 0, mk(12'h036, 7'b1111111, 3'd1, 3'd2, 3'd3), "rst_mid");
    cyc(0, 0, 0, 0, z, "rst_after");
    for (int i = 0; i < 400; i++)
      cyc($urandom % 60 == 0, $urandom % 25 == 0, $urandom % 4 != 0, $urandom % 3 != 0,
          mk(12'($urandom), 7'($urandom), 3'($urandom % 4), 3'($urandom % 4), 3'($urandom % 4)), "rand");
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
